// File: rtl/lcd_pkg.sv
// Shared LCD definitions: arbiter state encoding, LCD buffer geometry and
// the width of the arbiter idle timer. Other LCD blocks import this package.
package lcd_pkg;

  localparam int COL_W   = 4;
  localparam int CHAR_W  = 8;
  localparam int TIMER_W = 8;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    GRANT = 2'd2,
    FLUSH = 2'd3
  } lcd_state_t;

  typedef logic [TIMER_W-1:0] lcd_timer_t;

endpackage

// File: rtl/lcd_arbiter_if.sv
// Bus bundle between the two LCD clients, the arbiter and the LCD controller.
// The slave modport is the arbiter's view; master is the view of whatever
// drives the clients and the controller status.
interface lcd_arbiter_if;
  import lcd_pkg::*;

  logic              c0_req;
  logic              c1_req;
  logic              c0_gnt;
  logic              c1_gnt;

  logic              c0_row;
  logic              c1_row;
  logic [COL_W-1:0]  c0_col;
  logic [COL_W-1:0]  c1_col;
  logic [CHAR_W-1:0] c0_char;
  logic [CHAR_W-1:0] c1_char;
  logic              c0_we;
  logic              c1_we;
  logic              c0_update;
  logic              c1_update;

  logic              lcd_row;
  logic [COL_W-1:0]  lcd_col;
  logic [CHAR_W-1:0] lcd_char;
  logic              lcd_we;
  logic              update;
  logic              lcd_busy;

  modport slave (
    input  c0_req, c1_req,
    input  c0_row, c1_row, c0_col, c1_col, c0_char, c1_char,
    input  c0_we, c1_we, c0_update, c1_update,
    input  lcd_busy,
    output c0_gnt, c1_gnt,
    output lcd_row, lcd_col, lcd_char, lcd_we, update
  );

  modport master (
    output c0_req, c1_req,
    output c0_row, c1_row, c0_col, c1_col, c0_char, c1_char,
    output c0_we, c1_we, c0_update, c1_update,
    output lcd_busy,
    input  c0_gnt, c1_gnt,
    input  lcd_row, lcd_col, lcd_char, lcd_we, update
  );

endinterface

// File: rtl/lcd_arbiter.sv
// Two-client LCD arbiter. One client at a time owns the LCD buffer write
// port; a session ends with the owner's update pulse, with the owner dropping
// its request, or with an arbiter-generated update after TIMEOUT idle cycles.
// Ties are broken round-robin against the last owner.
module lcd_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          CLK,
  input  logic          RST,
  lcd_arbiter_if.slave  bus
);

  localparam lcd_timer_t TIMEOUT_VAL = lcd_timer_t'(TIMEOUT);

  lcd_state_t state;
  lcd_state_t next_state;
  logic       owner;
  logic       next_owner;
  logic       last_owner;
  logic       next_last_owner;
  lcd_timer_t timer;
  lcd_timer_t next_timer;
  logic       c0_gnt_q;
  logic       c1_gnt_q;

  logic              pick;
  logic              owner_req;
  logic              owner_row;
  logic [COL_W-1:0]  owner_col;
  logic [CHAR_W-1:0] owner_char;
  logic              owner_we;
  logic              owner_update;
  logic              timeout_hit;

  logic              out_row;
  logic [COL_W-1:0]  out_col;
  logic [CHAR_W-1:0] out_char;
  logic              out_we;
  logic              out_update;

  // Round-robin pick: a lone requester wins, a tie goes to the client that
  // did not own the port last time.
  assign pick = (bus.c0_req && bus.c1_req) ? ~last_owner : bus.c1_req;

  // Current owner's signals, selected once and shared by control and datapath.
  assign owner_req    = owner ? bus.c1_req    : bus.c0_req;
  assign owner_row    = owner ? bus.c1_row    : bus.c0_row;
  assign owner_col    = owner ? bus.c1_col    : bus.c0_col;
  assign owner_char   = owner ? bus.c1_char   : bus.c0_char;
  assign owner_we     = owner ? bus.c1_we     : bus.c0_we;
  assign owner_update = owner ? bus.c1_update : bus.c0_update;

  // The timer is compared in its registered form, so a write in the very
  // cycle the limit is reached does not cancel the forced release.
  assign timeout_hit = (state == GRANT) && (timer == TIMEOUT_VAL);

  // Next-state, owner selection and idle-timer bookkeeping.
  always_comb begin
    next_state      = state;
    next_owner      = owner;
    next_last_owner = last_owner;
    next_timer      = timer;
    case (state)
      INIT: begin
        if (!bus.lcd_busy) begin
          next_state = IDLE;
        end
      end
      IDLE: begin
        if (bus.c0_req || bus.c1_req) begin
          next_state      = GRANT;
          next_owner      = pick;
          next_last_owner = pick;
          next_timer      = '0;
        end
      end
      GRANT: begin
        if (owner_we) begin
          next_timer = '0;
        end else if (timer != {TIMER_W{1'b1}}) begin
          next_timer = timer + lcd_timer_t'(1);
        end
        if (owner_update || timeout_hit) begin
          next_state = FLUSH;
        end else if (!owner_req) begin
          next_state = IDLE;
        end
      end
      FLUSH: begin
        if (!bus.lcd_busy) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = INIT;
      end
    endcase
  end

  // State, owner, timer and registered grant flops with asynchronous reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= INIT;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      timer      <= '0;
      c0_gnt_q   <= 1'b0;
      c1_gnt_q   <= 1'b0;
    end else begin
      state      <= next_state;
      owner      <= next_owner;
      last_owner <= next_last_owner;
      timer      <= next_timer;
      c0_gnt_q   <= (next_state == GRANT) && !next_owner;
      c1_gnt_q   <= (next_state == GRANT) &&  next_owner;
    end
  end

  // LCD write port: transparent path from the owner during a session,
  // quiet zeros in every other state.
  always_comb begin
    out_row    = 1'b0;
    out_col    = '0;
    out_char   = '0;
    out_we     = 1'b0;
    out_update = 1'b0;
    if (state == GRANT) begin
      out_row    = owner_row;
      out_col    = owner_col;
      out_char   = owner_char;
      out_we     = owner_we;
      out_update = owner_update || timeout_hit;
    end
  end

  assign bus.c0_gnt   = c0_gnt_q;
  assign bus.c1_gnt   = c1_gnt_q;
  assign bus.lcd_row  = out_row;
  assign bus.lcd_col  = out_col;
  assign bus.lcd_char = out_char;
  assign bus.lcd_we   = out_we;
  assign bus.update   = out_update;

endmodule

// File: tb/tb_lcd_arbiter.sv
// Bench for lcd_arbiter: a hand-written vector table for the directed
// scenarios, a mid-session reset, then random traffic against a session model.
module tb_lcd_arbiter;
  import lcd_pkg::*;

  localparam int TB_TIMEOUT = 4;

  typedef struct {
    logic       req0, req1, busy;
    logic       row0, row1;
    logic [3:0] col0, col1;
    logic [7:0] ch0, ch1;
    logic       we0, we1, upd0, upd1;
  } stim_t;

  typedef struct {
    logic       gnt0, gnt1, row;
    logic [3:0] col;
    logic [7:0] ch;
    logic       we, upd;
  } resp_t;

  typedef struct {
    stim_t s;
    resp_t e;
  } vec_t;

  logic CLK = 1'b0;
  logic RST;
  int   n_compared   = 0;
  int   n_mismatched = 0;
  vec_t vecs[$];

  // Session model: who owns the port, whether init is done, whether a
  // refresh is draining, cycles since grant/last write, and the last owner.
  int   m_owner;
  bit   m_ready;
  bit   m_flush;
  int   m_quiet;
  int   m_last;

  // Free-running clock.
  always #5 CLK = ~CLK;

  lcd_arbiter_if bus();

  lcd_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  function automatic stim_t st(input logic r0, input logic r1, input logic b);
    stim_t s;
    s.req0 = r0; s.req1 = r1; s.busy = b;
    s.row0 = 1'b0; s.row1 = 1'b0; s.col0 = '0; s.col1 = '0;
    s.ch0 = '0; s.ch1 = '0;
    s.we0 = 1'b0; s.we1 = 1'b0; s.upd0 = 1'b0; s.upd1 = 1'b0;
    return s;
  endfunction

  function automatic resp_t rp(input logic g0, input logic g1);
    resp_t e;
    e.gnt0 = g0; e.gnt1 = g1; e.row = 1'b0; e.col = '0; e.ch = '0;
    e.we = 1'b0; e.upd = 1'b0;
    return e;
  endfunction

  task automatic add(input stim_t s, input resp_t e);
    vec_t v;
    v.s = s;
    v.e = e;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input stim_t s);
    bus.c0_req    = s.req0;  bus.c1_req    = s.req1;
    bus.lcd_busy  = s.busy;
    bus.c0_row    = s.row0;  bus.c1_row    = s.row1;
    bus.c0_col    = s.col0;  bus.c1_col    = s.col1;
    bus.c0_char   = s.ch0;   bus.c1_char   = s.ch1;
    bus.c0_we     = s.we0;   bus.c1_we     = s.we1;
    bus.c0_update = s.upd0;  bus.c1_update = s.upd1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  task automatic checkResp(input string tag, input resp_t e);
    checkOutput({tag, ".c0_gnt"},   16'(bus.c0_gnt),   16'(e.gnt0));
    checkOutput({tag, ".c1_gnt"},   16'(bus.c1_gnt),   16'(e.gnt1));
    checkOutput({tag, ".lcd_row"},  16'(bus.lcd_row),  16'(e.row));
    checkOutput({tag, ".lcd_col"},  16'(bus.lcd_col),  16'(e.col));
    checkOutput({tag, ".lcd_char"}, 16'(bus.lcd_char), 16'(e.ch));
    checkOutput({tag, ".lcd_we"},   16'(bus.lcd_we),   16'(e.we));
    checkOutput({tag, ".update"},   16'(bus.update),   16'(e.upd));
  endtask

  task automatic model_reset();
    m_owner = -1; m_ready = 1'b0; m_flush = 1'b0; m_quiet = 0; m_last = 1;
  endtask

  function automatic resp_t model_resp(input stim_t s);
    resp_t e;
    e = rp(m_owner == 0, m_owner == 1);
    if (m_owner >= 0) begin
      e.row = (m_owner == 0) ? s.row0 : s.row1;
      e.col = (m_owner == 0) ? s.col0 : s.col1;
      e.ch  = (m_owner == 0) ? s.ch0  : s.ch1;
      e.we  = (m_owner == 0) ? s.we0  : s.we1;
      e.upd = ((m_owner == 0) ? s.upd0 : s.upd1) || (m_quiet == TB_TIMEOUT);
    end
    return e;
  endfunction

  task automatic model_step(input stim_t s);
    bit o_req, o_we, o_upd;
    if (!m_ready) begin
      if (!s.busy) m_ready = 1'b1;
    end else if (m_owner >= 0) begin
      o_req = (m_owner == 0) ? s.req0 : s.req1;
      o_we  = (m_owner == 0) ? s.we0  : s.we1;
      o_upd = (m_owner == 0) ? s.upd0 : s.upd1;
      if (o_upd || m_quiet == TB_TIMEOUT) begin
        m_owner = -1;
        m_flush = 1'b1;
      end else if (!o_req) begin
        m_owner = -1;
      end else if (o_we) begin
        m_quiet = 0;
      end else if (m_quiet < 255) begin
        m_quiet++;
      end
    end else if (m_flush) begin
      if (!s.busy) m_flush = 1'b0;
    end else if (s.req0 || s.req1) begin
      if (s.req0 && s.req1) m_owner = 1 - m_last;
      else                  m_owner = s.req0 ? 0 : 1;
      m_last  = m_owner;
      m_quiet = 0;
    end
  endtask

  // Main test sequence.
  initial begin
    stim_t s;
    resp_t e;
    bit    r0, r1;

    RST = 1'b0;
    applyStimulus(st(0, 0, 0));

    // Directed table: one row per clock, outputs checked mid-cycle.
    repeat (10) add(st(1, 0, 1), rp(0, 0));
    add(st(1, 1, 0), rp(0, 0));
    add(st(1, 1, 0), rp(0, 0));
    s = st(1, 1, 0); s.we0 = 1; s.row0 = 0; s.col0 = 4'd3; s.ch0 = 8'h41;
    s.we1 = 1; s.upd1 = 1; s.row1 = 1; s.col1 = 4'd9; s.ch1 = 8'h77;
    e = rp(1, 0); e.col = 4'd3; e.ch = 8'h41; e.we = 1; add(s, e);
    s = st(1, 1, 0); s.row0 = 1; s.col0 = 4'd5; s.ch0 = 8'h42;
    e = rp(1, 0); e.row = 1; e.col = 4'd5; e.ch = 8'h42; add(s, e);
    s = st(1, 1, 0); s.upd0 = 1; e = rp(1, 0); e.upd = 1; add(s, e);
    add(st(1, 1, 1), rp(0, 0));
    add(st(1, 1, 0), rp(0, 0));
    add(st(1, 1, 0), rp(0, 0));
    s = st(1, 1, 0); s.we0 = 1; s.ch0 = 8'h5A; s.col1 = 4'd2; s.ch1 = 8'h30;
    e = rp(0, 1); e.col = 4'd2; e.ch = 8'h30; add(s, e);
    s = st(1, 0, 0); s.we0 = 1; s.upd0 = 1; s.ch0 = 8'h5A; add(s, rp(0, 1));
    add(st(1, 0, 0), rp(0, 0));
    s = st(0, 0, 0); s.upd0 = 1; e = rp(1, 0); e.upd = 1; add(s, e);
    add(st(0, 1, 0), rp(0, 0));
    add(st(0, 1, 0), rp(0, 0));
    repeat (4) add(st(0, 1, 0), rp(0, 1));
    e = rp(0, 1); e.upd = 1; add(st(0, 1, 0), e);
    add(st(0, 1, 1), rp(0, 0));
    add(st(0, 1, 0), rp(0, 0));
    add(st(0, 1, 0), rp(0, 0));
    add(st(0, 1, 0), rp(0, 1));

    // Reset state with busy clients pushing on every input.
    s = st(1, 1, 0); s.we0 = 1; s.upd0 = 1; s.ch0 = 8'hFF; s.col0 = 4'hF; s.row0 = 1;
    s.we1 = 1; s.upd1 = 1;
    applyStimulus(s);
    repeat (3) @(negedge CLK);
    #1 checkResp("reset", rp(0, 0));

    @(negedge CLK);
    applyStimulus(st(1, 0, 1));
    RST = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      applyStimulus(vecs[i].s);
      #1 checkResp($sformatf("vec%0d", i), vecs[i].e);
    end

    // Reset in the middle of a c1 session: grant drops at once, no update.
    @(negedge CLK);
    s = st(0, 1, 0); s.upd1 = 1; s.we1 = 1; s.ch1 = 8'h11;
    applyStimulus(s);
    #1 checkOutput("pre_reset.c1_gnt", 16'(bus.c1_gnt), 16'd1);
    RST = 1'b0;
    #1 checkResp("mid_reset", rp(0, 0));

    // Random traffic against the session model.
    @(negedge CLK);
    applyStimulus(st(0, 0, 1));
    @(negedge CLK);
    RST = 1'b1;
    model_reset();
    r0 = 1'b0;
    r1 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if ($urandom_range(7) == 0) r0 = ~r0;
      if ($urandom_range(7) == 0) r1 = ~r1;
      s = st(r0, r1, $urandom_range(2) == 0);
      s.row0 = 1'($urandom);  s.row1 = 1'($urandom);
      s.col0 = 4'($urandom);  s.col1 = 4'($urandom);
      s.ch0  = 8'($urandom);  s.ch1  = 8'($urandom);
      s.we0  = ($urandom_range(3) == 0);
      s.we1  = ($urandom_range(3) == 0);
      s.upd0 = ($urandom_range(9) == 0);
      s.upd1 = ($urandom_range(9) == 0);
      applyStimulus(s);
      #1 checkResp($sformatf("rand%0d", i), model_resp(s));
      model_step(s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/lcd_arbiter.md
LCD_ARBITER -- requirements
Module: lcd_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the number of idle granted cycles before a forced release (range 1..255).
REQ-002 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports c0_req, c1_req  input  1 each  client requests LCD ownership; held high for the whole session.
REQ-005 SHALL have ports c0_gnt, c1_gnt  output  1 each  client owns the LCD write port; registered.
REQ-006 SHALL have ports cN_row  input  1  client row select.
REQ-007 SHALL have ports cN_col  input  4  client column.
REQ-008 SHALL have ports cN_char  input  8  client character code.
REQ-009 SHALL have ports cN_we  input  1  client character write strobe.
REQ-010 SHALL have ports cN_update  input  1  client end-of-session refresh pulse.
REQ-011 SHALL have ports lcd_row (1), lcd_col (4), lcd_char (8), lcd_we (1), update (1)  output  LCD buffer write port and refresh strobe.
REQ-012 SHALL have port lcd_busy  input  1  LCD controller busy (init or refresh in progress).

Function
REQ-013 SHALL implement states INIT, IDLE, GRANT and FLUSH.
REQ-014 INIT -> IDLE when lcd_busy=0; no grant SHALL be issued in INIT.
REQ-015 IDLE -> GRANT when any cN_req=1, with the owner chosen in that cycle.
REQ-016 Owner selection in IDLE:
- single requester wins;
- when both request, the winner is the client not recorded as last owner;
- last-owner register updated on every grant.
REQ-017 cN_gnt=1 exactly while state=GRANT and owner=N; grant appears the cycle after req is sampled in IDLE.
REQ-018 In GRANT, lcd_row/lcd_col/lcd_char/lcd_we/update SHALL combinationally follow the owner's inputs (zero latency).
REQ-019 Non-owner cN_we and cN_update SHALL be ignored.
REQ-020 Outside GRANT, lcd_we=0 and lcd_row/lcd_col/lcd_char=0; update=0 except per REQ-024.
REQ-021 GRANT -> FLUSH on the cycle owner cN_update=1; that update pulse SHALL reach the update output in the same cycle.
REQ-022 GRANT -> IDLE when owner drops cN_req without update.
- No update is emitted.
- If owner drops req and pulses update in the same cycle, update wins and the state goes to FLUSH.
REQ-023 Idle timer SHALL be 8 bits:
- cleared on grant and on every owner cN_we=1;
- incremented otherwise while in GRANT;
- saturates, with no wrap.
REQ-024 When the timer reaches TIMEOUT in GRANT, the arbiter SHALL drive update=1 for one cycle itself, drop the grant, and enter FLUSH.
REQ-025 FLUSH SHALL last at least one cycle; FLUSH -> IDLE on the first cycle after entry with lcd_busy=0.
REQ-026 Requests arriving in INIT, GRANT or FLUSH SHALL be held pending; no request is lost while cN_req stays high.
REQ-027 A client whose req stays high after its own FLUSH SHALL lose to a waiting other client (round-robin fairness).

Reset
REQ-028 On RST=0:
- state=INIT, c0_gnt=c1_gnt=0, lcd_we=0, update=0;
- lcd_row=0, lcd_col=0, lcd_char=0;
- timer=0, last owner=client 1 (client 0 wins the first tie).
REQ-029 Reset asserted mid-session SHALL drop the grant immediately without emitting update.

Structure
REQ-030 State encoding, COL_W=4 and CHAR_W=8 SHALL live in shared package lcd_pkg, reused by the other LCD blocks.
REQ-031 The block SHALL be a single module with no sub-modules; the round-robin pick is inline logic.

Verification
REQ-032 Reset release with lcd_busy=1 for 10 cycles, c0_req=1 -> c0_gnt stays 0 until lcd_busy=0, then rises 2 cycles later (INIT -> IDLE -> GRANT).
REQ-033 c0 writes row=0, col=3, char=8'h41 with we=1 while granted -> same cycle lcd_row=0, lcd_col=3, lcd_char=8'h41, lcd_we=1.
REQ-034 c0 and c1 request together from IDLE after reset -> c0 granted first; after c0 update and lcd_busy low, c1 granted even though c0_req is still 1.
REQ-035 TIMEOUT=4, c1 granted with no writes -> update=1 for one cycle 4 cycles after grant, c1_gnt=0, state FLUSH.
REQ-036 c1 granted, c0_we=1 with char=8'h5A -> lcd_we=0 and lcd_char unaffected.
- Then c1 drops req without update -> update never asserted; IDLE next cycle.
